// File: rtl/ne16_package.sv
// ne16_package: shared types and sizes for the NE16 normquant parameter loader.
package ne16_package;
  localparam int NORM_MULT_SIZE = 8;
  localparam int NOF_CHAN_W     = 6;
  typedef enum logic [1:0] {IDLE, LOAD_SCALE, LOAD_SHIFT, LOADED} nq_state_e;
  typedef struct packed {
    logic                  start;
    logic [NOF_CHAN_W-1:0] nof_chan;
    logic                  shift_uniform;
    logic [4:0]            shift_value;
  } nq_ctrl_t;
endpackage

// File: rtl/ne16_normquant_param_loader.sv
// ne16_normquant_param_loader: streams per-channel norm multipliers and shifts into flop buffers and serves them per group.
module ne16_normquant_param_loader
  import ne16_package::*;
#(
  parameter int NMULT = 4,
  parameter int NMS   = NORM_MULT_SIZE,
  parameter int TP    = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         test_mode_i,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [$clog2(TP):0]          nof_chan_i,
  input  logic                         shift_uniform_i,
  input  logic [4:0]                   shift_value_i,
  input  logic [31:0]                  stream_data_i,
  input  logic                         stream_valid_i,
  output logic                         stream_ready_o,
  output logic                         busy_o,
  output logic                         done_o,
  input  logic                         rd_en_i,
  input  logic [$clog2(TP/NMULT)-1:0]  rd_group_i,
  output logic [NMULT*NMS-1:0]         norm_mult_o,
  output logic [NMULT*8-1:0]           shift_o,
  output logic                         rd_valid_o
);
  localparam int CW  = $clog2(TP) + 1;
  localparam int CHW = $clog2(TP);
  localparam int BW  = $clog2(TP/4) + 1;
  nq_state_e state_q, state_d;
  nq_ctrl_t ctrl_q, ctrl_in;
  logic [BW-1:0] beat_q, w;
  logic [CW-1:0] nof;
  logic [NMS-1:0] scale_q [TP];
  logic [7:0] shift_q [TP];
  logic [NMULT*NMS-1:0] norm_mult_q, rd_scale;
  logic [NMULT*8-1:0] shift_out_q, rd_shift;
  logic done_q, rd_valid_q, accept, last_beat, start_ok, rd_fire;
  logic unused_bits;
  assign unused_bits    = test_mode_i | ctrl_q.start;
  assign ctrl_in        = '{start: start_i, nof_chan: NOF_CHAN_W'(nof_chan_i),
                            shift_uniform: shift_uniform_i, shift_value: shift_value_i};
  assign nof            = CW'(ctrl_q.nof_chan);
  assign w              = BW'(({1'b0, nof} + (CW+1)'(3)) >> 2);
  assign busy_o         = state_q == LOAD_SCALE || state_q == LOAD_SHIFT;
  assign stream_ready_o = busy_o;
  assign accept         = stream_valid_i & stream_ready_o;
  assign last_beat      = accept && beat_q == w - BW'(1);
  assign start_ok       = start_i && (state_q == IDLE || state_q == LOADED);
  assign rd_fire        = rd_en_i && state_q == LOADED;
  assign done_o         = done_q;
  assign rd_valid_o     = rd_valid_q;
  assign norm_mult_o    = norm_mult_q;
  assign shift_o        = shift_out_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOADED: state_d = start_i ? LOAD_SCALE : state_q;
      LOAD_SCALE:   state_d = last_beat ? (ctrl_q.shift_uniform ? LOADED : LOAD_SHIFT) : state_q;
      LOAD_SHIFT:   state_d = last_beat ? LOADED : state_q;
      default:      state_d = IDLE;
    endcase
  end
  // Uniform mode synthesises shifts from the captured value instead of the buffer.
  always_comb begin
    rd_scale = '0;
    rd_shift = '0;
    for (int i = 0; i < NMULT; i++) begin
      rd_scale[i*NMS +: NMS] = scale_q[CHW'(NMULT*int'(rd_group_i) + i)];
      rd_shift[i*8 +: 8] = ctrl_q.shift_uniform
        ? ((CW'(NMULT*int'(rd_group_i) + i) < nof) ? {3'b0, ctrl_q.shift_value} : 8'h00)
        : shift_q[CHW'(NMULT*int'(rd_group_i) + i)];
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= clear_i ? IDLE : state_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q      <= '0;
      beat_q      <= '0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      norm_mult_q <= '0;
      shift_out_q <= '0;
      for (int c = 0; c < TP; c++) begin
        scale_q[c] <= '0;
        shift_q[c] <= '0;
      end
    end else if (clear_i) begin
      ctrl_q      <= '0;
      beat_q      <= '0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      norm_mult_q <= '0;
      shift_out_q <= '0;
      for (int c = 0; c < TP; c++) begin
        scale_q[c] <= '0;
        shift_q[c] <= '0;
      end
    end else begin
      done_q     <= last_beat && state_d == LOADED;
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        norm_mult_q <= rd_scale;
        shift_out_q <= rd_shift;
      end
      if (start_ok) begin
        ctrl_q <= ctrl_in;
        beat_q <= '0;
        for (int c = 0; c < TP; c++) begin
          scale_q[c] <= '0;
          shift_q[c] <= '0;
        end
      end else if (accept) begin
        beat_q <= last_beat ? '0 : beat_q + BW'(1);
        // Bytes past nof_chan in the final beat are dropped so the buffer stays zero.
        for (int c = 0; c < TP; c++) begin
          if (BW'(c/4) == beat_q && CW'(c) < nof) begin
            if (state_q == LOAD_SCALE) scale_q[c] <= NMS'(stream_data_i[8*(c%4) +: 8]);
            else                       shift_q[c] <= {3'b0, stream_data_i[8*(c%4) +: 5]};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ne16_normquant_param_loader.sv
// tb_ne16_normquant_param_loader: directed table-driven checks of loading, reading, clear and corner cases.
module tb_ne16_normquant_param_loader;
  logic clk = 1'b0, rst_ni = 1'b0, test_mode_i = 1'b0, clear_i = 1'b0, start_i = 1'b0;
  logic [5:0] nof_chan_i = '0;
  logic shift_uniform_i = 1'b0;
  logic [4:0] shift_value_i = '0;
  logic [31:0] stream_data_i = '0;
  logic stream_valid_i = 1'b0, stream_ready_o, busy_o, done_o, rd_en_i = 1'b0, rd_valid_o;
  logic [2:0] rd_group_i = '0;
  logic [31:0] norm_mult_o, shift_o;
  int n_chk = 0, n_fail = 0;
  ne16_normquant_param_loader dut (
    .clk_i(clk), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
    .start_i(start_i), .nof_chan_i(nof_chan_i), .shift_uniform_i(shift_uniform_i),
    .shift_value_i(shift_value_i), .stream_data_i(stream_data_i), .stream_valid_i(stream_valid_i),
    .stream_ready_o(stream_ready_o), .busy_o(busy_o), .done_o(done_o), .rd_en_i(rd_en_i),
    .rd_group_i(rd_group_i), .norm_mult_o(norm_mult_o), .shift_o(shift_o), .rd_valid_o(rd_valid_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    int          cfg;
    int          grp;
    logic [31:0] nm;
    logic [31:0] sh;
  } vec_t;
  vec_t tbl[9];
  logic [31:0] sc_full[8], sh_full[8], sc_part[8], sh_part[8], sc_uni[8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic start_load(input int nof, input bit uni, input int sval);
    start_i = 1'b1;
    nof_chan_i = 6'(nof);
    shift_uniform_i = uni;
    shift_value_i = 5'(sval);
    tick();
    start_i = 1'b0;
  endtask
  task automatic stream(input int nof, input bit uni, input logic [31:0] sc[8],
                        input logic [31:0] sh[8], input bit bp);
    int w = (nof + 3) / 4;
    int dn = 0;
    for (int ph = 0; ph < (uni ? 1 : 2); ph++)
      for (int b = 0; b < w; b++) begin
        for (int k = 0; bp && k < 4 && $urandom_range(0, 1) == 0; k++) begin
          stream_valid_i = 1'b0;
          tick();
          dn += int'(done_o);
        end
        stream_valid_i = 1'b1;
        stream_data_i = (ph == 0) ? sc[b] : sh[b];
        chk("ready_in_load", {31'b0, stream_ready_o}, 1);
        tick();
        dn += int'(done_o);
      end
    stream_valid_i = 1'b1;
    stream_data_i = 32'hDEADBEEF;
    chk("done_pulse", {31'b0, done_o}, 1);
    chk("busy_loaded", {31'b0, busy_o}, 0);
    chk("ready_after_w", {31'b0, stream_ready_o}, 0);
    tick();
    stream_valid_i = 1'b0;
    dn += int'(done_o);
    chk("done_once", 32'(dn), 1);
  endtask
  task automatic rd(input int g, input logic [31:0] nm, input logic [31:0] sh);
    rd_en_i = 1'b1;
    rd_group_i = 3'(g);
    tick();
    rd_en_i = 1'b0;
    chk("rd_valid", {31'b0, rd_valid_o}, 1);
    chk("norm_mult", norm_mult_o, nm);
    chk("shift", shift_o, sh);
  endtask
  initial begin
    int cur;
    for (int b = 0; b < 8; b++) begin
      sc_full[b] = {8'(4*b+4), 8'(4*b+3), 8'(4*b+2), 8'(4*b+1)};
      sh_full[b] = 32'h05050505;
      sc_part[b] = 32'h0;
      sh_part[b] = 32'h0;
      sc_uni[b]  = 32'h0;
    end
    sc_part[0] = 32'h44332211; sc_part[1] = 32'hFFEE6655;
    sh_part[0] = 32'h1F3F0201; sh_part[1] = 32'hAAAA0403;
    sc_uni[0]  = 32'h0D0C0B0A; sc_uni[1]  = 32'h99887766;
    tbl[0] = '{0, 0, 32'h04030201, 32'h05050505};
    tbl[1] = '{0, 1, 32'h08070605, 32'h05050505};
    tbl[2] = '{0, 7, 32'h201F1E1D, 32'h05050505};
    tbl[3] = '{1, 0, 32'h44332211, 32'h1F1F0201};
    tbl[4] = '{1, 1, 32'h00006655, 32'h00000403};
    tbl[5] = '{1, 2, 32'h00000000, 32'h00000000};
    tbl[6] = '{2, 0, 32'h0D0C0B0A, 32'h0D0D0D0D};
    tbl[7] = '{2, 1, 32'h00000066, 32'h0000000D};
    tbl[8] = '{2, 7, 32'h00000000, 32'h00000000};
    #2;
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_ready", {31'b0, stream_ready_o}, 0);
    chk("rst_done", {31'b0, done_o}, 0);
    chk("rst_rd_valid", {31'b0, rd_valid_o}, 0);
    chk("rst_norm", norm_mult_o, 0);
    chk("rst_shift", shift_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    cur = -1;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].cfg != cur) begin
        cur = tbl[i].cfg;
        if (cur == 0) begin start_load(32, 0, 0); stream(32, 0, sc_full, sh_full, 0); end
        if (cur == 1) begin start_load(6, 0, 0);  stream(6, 0, sc_part, sh_part, 0); end
        if (cur == 2) begin start_load(5, 1, 13); stream(5, 1, sc_uni, sh_part, 0); end
      end
      rd(tbl[i].grp, tbl[i].nm, tbl[i].sh);
    end
    tick();
    chk("hold_norm", norm_mult_o, 32'h0);
    chk("hold_rd_valid", {31'b0, rd_valid_o}, 0);
    rd(0, 32'h0D0C0B0A, 32'h0D0D0D0D);
    rd_en_i = 1'b1;
    rd_group_i = 3'd0;
    start_i = 1'b1;
    nof_chan_i = 6'd32;
    shift_uniform_i = 1'b0;
    tick();
    rd_en_i = 1'b0;
    start_i = 1'b0;
    chk("rdstart_valid", {31'b0, rd_valid_o}, 1);
    chk("rdstart_norm", norm_mult_o, 32'h0D0C0B0A);
    chk("rdstart_busy", {31'b0, busy_o}, 1);
    rd_en_i = 1'b1;
    rd_group_i = 3'd1;
    tick();
    rd_en_i = 1'b0;
    chk("rd_in_load_valid", {31'b0, rd_valid_o}, 0);
    chk("rd_in_load_norm", norm_mult_o, 32'h0D0C0B0A);
    stream(32, 0, sc_full, sh_full, 1);
    for (int g = 0; g < 8; g++) rd(g, sc_full[g], 32'h05050505);
    start_load(32, 0, 0);
    for (int b = 0; b < 3; b++) begin
      stream_valid_i = 1'b1;
      stream_data_i = sc_full[b];
      tick();
    end
    stream_data_i = sc_full[3];
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    stream_valid_i = 1'b0;
    chk("clr_busy", {31'b0, busy_o}, 0);
    chk("clr_ready", {31'b0, stream_ready_o}, 0);
    chk("clr_done", {31'b0, done_o}, 0);
    chk("clr_norm", norm_mult_o, 0);
    chk("clr_shift", shift_o, 0);
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    chk("idle_rd_valid", {31'b0, rd_valid_o}, 0);
    start_load(32, 0, 0);
    stream(32, 0, sc_full, sh_full, 0);
    rd(0, 32'h04030201, 32'h05050505);
    rd(5, 32'h18171615, 32'h05050505);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
